// File: rtl/clk_ctrl_pkg.sv
// Shared encodings for the CPU slow-clock controller: debug mode values and FSM states.
package clk_ctrl_pkg;

    typedef logic [1:0] mode_t;
    typedef logic [1:0] state_t;

    localparam mode_t MODE_HALT = 2'b00;
    localparam mode_t MODE_RUN  = 2'b01;
    localparam mode_t MODE_STEP = 2'b10;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_RUN      = 2'd1;
    localparam state_t ST_STEP_RUN = 2'd2;

endpackage

// File: rtl/clk_ctrl_if.sv
// Debug-side control and status bundle of the slow-clock controller.
// master = debug logic / testbench, slave = clk_ctrl.
interface clk_ctrl_if #(
    parameter int CNT_W  = 32,
    parameter int TCNT_W = 16
);
    import clk_ctrl_pkg::*;

    mode_t              mode;
    logic               step_req;
    logic               div_wr;
    logic [CNT_W-1:0]   div_data;
    logic               div_busy;
    logic               div_ack;
    logic               clk_out;
    logic               tick;
    logic               step_done;
    logic [TCNT_W-1:0]  tick_cnt;

    modport master (
        output mode, step_req, div_wr, div_data,
        input  div_busy, div_ack, clk_out, tick, step_done, tick_cnt
    );

    modport slave (
        input  mode, step_req, div_wr, div_data,
        output div_busy, div_ack, clk_out, tick, step_done, tick_cnt
    );

endinterface

// File: rtl/clk_period_cnt.sv
// Period counter: counts 0..div-1 while enabled, flags the last cycle, registers clk_out/tick.
// Latency: clk_out/tick lag the counter by one cycle; boundary is combinational from cnt.
// Backpressure: none; div must only change while cnt is 0 or at the boundary.
module clk_period_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic             boundary,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] half;

    assign last     = div - ONE;
    assign half     = div >> 1;
    assign boundary = en && (cnt == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (!en || boundary)
                cnt <= '0;
            else
                cnt <= cnt + ONE;
            clk_out <= en && (cnt < half);
            tick    <= boundary;
        end
    end

endmodule

// File: rtl/clk_ctrl.sv
// Run/halt/single-step controller with runtime-programmable divisor for the CPU slow clock.
// Latency: clk_out rises two cycles after RUN is requested; divisor writes land at the next boundary.
// Backpressure: div_busy high while a write is pending; further div_wr are dropped, not queued.
module clk_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int               CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = 50_000_000,
    parameter logic [CNT_W-1:0] MIN_DIV     = 2,
    parameter int               TCNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    clk_ctrl_if.slave  bus
);

    localparam logic [TCNT_W-1:0] TONE = {{(TCNT_W-1){1'b0}}, 1'b1};

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   div_reg;
    logic [CNT_W-1:0]   pend_val;
    logic               pend_vld;
    logic               div_ack;
    logic               step_done;
    logic [TCNT_W-1:0]  tick_cnt;
    logic               boundary;
    logic               active;
    logic               accept;
    logic               apply;

    assign active = (state != ST_IDLE);

    // Mode is only sampled when idle or on the last cycle of a period.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.mode == MODE_RUN)
                    state_nxt = ST_RUN;
                else if (bus.mode == MODE_STEP && bus.step_req)
                    state_nxt = ST_STEP_RUN;
            end
            ST_RUN: begin
                if (boundary && bus.mode != MODE_RUN)
                    state_nxt = ST_IDLE;
            end
            ST_STEP_RUN: begin
                if (boundary)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // apply needs the registered pending flag, so a write on a boundary waits a full period.
    assign accept = bus.div_wr && !pend_vld;
    assign apply  = pend_vld && (!active || boundary);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            div_reg   <= DEFAULT_DIV;
            pend_val  <= '0;
            pend_vld  <= 1'b0;
            div_ack   <= 1'b0;
            step_done <= 1'b0;
            tick_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (apply) begin
                div_reg  <= pend_val;
                pend_vld <= 1'b0;
            end else if (accept) begin
                pend_val <= (bus.div_data < MIN_DIV) ? MIN_DIV : bus.div_data;
                pend_vld <= 1'b1;
            end
            div_ack   <= apply;
            step_done <= (state == ST_STEP_RUN) && boundary;
            if (boundary)
                tick_cnt <= tick_cnt + TONE;
        end
    end

    clk_period_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (active),
        .div      (div_reg),
        .boundary (boundary),
        .clk_out  (bus.clk_out),
        .tick     (bus.tick)
    );

    assign bus.div_busy  = pend_vld;
    assign bus.div_ack   = div_ack;
    assign bus.step_done = step_done;
    assign bus.tick_cnt  = tick_cnt;

endmodule

// File: tb/tb_clk_ctrl.sv
// Scoreboard bench for clk_ctrl: expected periods and divisor acks are queued by the stimulus
// and checked by a negedge monitor on every tick / div_ack.
module tb_clk_ctrl;
    import clk_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    clk_ctrl_if #(.CNT_W(32), .TCNT_W(4)) bus ();

    clk_ctrl #(
        .CNT_W       (32),
        .DEFAULT_DIV (32'd4),
        .MIN_DIV     (32'd2),
        .TCNT_W      (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pat;
        int          len;
        logic        sd;
        logic [3:0]  tcnt;
    } per_t;

    per_t exp_q[$];
    int   ack_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_ticks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_per(input logic [31:0] pat, input int len, input logic sd);
        per_t e;
        exp_ticks++;
        e.pat  = pat;
        e.len  = len;
        e.sd   = sd;
        e.tcnt = 4'(exp_ticks);
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: a period starts on the first high clk_out after a tick and ends on the tick.
    logic [31:0] m_pat = '0;
    int          m_len = 0;
    bit          m_in  = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_in  = 1'b0;
            m_len = 0;
            m_pat = '0;
        end else begin
            if (!m_in && bus.clk_out) begin
                m_in  = 1'b1;
                m_pat = 32'd1;
                m_len = 1;
            end else if (m_in) begin
                m_pat = {m_pat[30:0], bus.clk_out};
                m_len++;
            end
            if (bus.step_done)
                chk("step_done_has_tick", {31'd0, bus.tick}, 32'd1);
            if (bus.tick) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_tick: tick_cnt=%0d, no period expected", bus.tick_cnt);
                end else begin
                    per_t e;
                    e = exp_q.pop_front();
                    chk("period_pattern", m_pat, e.pat);
                    chk("period_len", m_len, e.len);
                    chk("step_done", {31'd0, bus.step_done}, {31'd0, e.sd});
                    chk("tick_cnt", {28'd0, bus.tick_cnt}, {28'd0, e.tcnt});
                end
                m_in  = 1'b0;
                m_len = 0;
                m_pat = '0;
            end
            if (bus.div_ack) begin
                if (ack_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_div_ack: div_ack=1, no ack expected");
                end else begin
                    void'(ack_q.pop_front());
                    chk("busy_at_ack", {31'd0, bus.div_busy}, 32'd0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.mode     = MODE_HALT;
        bus.step_req = 1'b0;
        bus.div_wr   = 1'b0;
        bus.div_data = '0;
        cyc(3);
        rst_n = 1'b1;

        chk("rst_clk_out",   {31'd0, bus.clk_out},   32'd0);
        chk("rst_tick",      {31'd0, bus.tick},      32'd0);
        chk("rst_step_done", {31'd0, bus.step_done}, 32'd0);
        chk("rst_div_busy",  {31'd0, bus.div_busy},  32'd0);
        chk("rst_div_ack",   {31'd0, bus.div_ack},   32'd0);
        chk("rst_tick_cnt",  {28'd0, bus.tick_cnt},  32'd0);
        cyc(2);

        // 1: free run for 12 cycles, div 4
        for (int i = 0; i < 3; i++) push_per(32'b1100, 4, 1'b0);
        bus.mode = MODE_RUN;
        cyc(1);
        chk("t1_latency_1", {31'd0, bus.clk_out}, 32'd0);
        cyc(1);
        chk("t1_latency_2", {31'd0, bus.clk_out}, 32'd1);
        cyc(10);
        bus.mode = MODE_HALT;
        cyc(6);
        chk("t1_idle_clk_out", {31'd0, bus.clk_out}, 32'd0);
        chk("t1_tick_cnt", {28'd0, bus.tick_cnt}, 32'd3);

        // 2: step_req in HALT ignored; one STEP period, second pulse ignored
        bus.step_req = 1'b1;
        cyc(1);
        bus.step_req = 1'b0;
        cyc(4);
        push_per(32'b1100, 4, 1'b1);
        bus.mode     = MODE_STEP;
        bus.step_req = 1'b1;
        cyc(1);
        bus.step_req = 1'b0;
        cyc(1);
        bus.step_req = 1'b1;
        cyc(1);
        bus.step_req = 1'b0;
        cyc(10);
        chk("t2_idle_clk_out", {31'd0, bus.clk_out}, 32'd0);
        chk("t2_tick_cnt", {28'd0, bus.tick_cnt}, 32'd4);
        bus.mode = MODE_HALT;
        cyc(2);

        // 3: halt requested mid-period; period still completes
        push_per(32'b1100, 4, 1'b0);
        bus.mode = MODE_RUN;
        cyc(2);
        bus.mode = MODE_HALT;
        cyc(8);
        chk("t3_idle_clk_out", {31'd0, bus.clk_out}, 32'd0);
        chk("t3_tick_cnt", {28'd0, bus.tick_cnt}, 32'd5);

        // 4: divisor 6 written mid-period, second write while busy dropped
        push_per(32'b1100, 4, 1'b0);
        push_per(32'b111000, 6, 1'b0);
        ack_q.push_back(1);
        bus.mode = MODE_RUN;
        cyc(2);
        bus.div_wr   = 1'b1;
        bus.div_data = 32'd6;
        cyc(1);
        chk("t4_busy", {31'd0, bus.div_busy}, 32'd1);
        bus.div_data = 32'd8;
        cyc(1);
        bus.div_wr = 1'b0;
        chk("t4_busy_after_drop", {31'd0, bus.div_busy}, 32'd1);
        cyc(2);
        bus.mode = MODE_HALT;
        cyc(10);
        chk("t4_busy_cleared", {31'd0, bus.div_busy}, 32'd0);
        chk("t4_tick_cnt", {28'd0, bus.tick_cnt}, 32'd7);

        // 5: divisor 1 in IDLE clamps to 2
        bus.div_wr   = 1'b1;
        bus.div_data = 32'd1;
        ack_q.push_back(1);
        cyc(1);
        bus.div_wr = 1'b0;
        chk("t5_busy", {31'd0, bus.div_busy}, 32'd1);
        cyc(3);
        chk("t5_busy_cleared", {31'd0, bus.div_busy}, 32'd0);
        for (int i = 0; i < 3; i++) push_per(32'b10, 2, 1'b0);
        bus.mode = MODE_RUN;
        cyc(6);
        bus.mode = MODE_HALT;
        cyc(6);
        chk("t5_tick_cnt", {28'd0, bus.tick_cnt}, 32'd10);

        // 6: divisor 6, run, pending write of 8, reset at cnt=2
        bus.div_wr   = 1'b1;
        bus.div_data = 32'd6;
        ack_q.push_back(1);
        cyc(1);
        bus.div_wr = 1'b0;
        cyc(3);
        bus.mode = MODE_RUN;
        cyc(2);
        bus.div_wr   = 1'b1;
        bus.div_data = 32'd8;
        cyc(1);
        bus.div_wr = 1'b0;
        chk("t6_pre_clk_out", {31'd0, bus.clk_out}, 32'd1);
        chk("t6_pre_busy", {31'd0, bus.div_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_clk_out",   {31'd0, bus.clk_out},   32'd0);
        chk("t6_rst_tick",      {31'd0, bus.tick},      32'd0);
        chk("t6_rst_step_done", {31'd0, bus.step_done}, 32'd0);
        chk("t6_rst_div_busy",  {31'd0, bus.div_busy},  32'd0);
        chk("t6_rst_div_ack",   {31'd0, bus.div_ack},   32'd0);
        chk("t6_rst_tick_cnt",  {28'd0, bus.tick_cnt},  32'd0);
        bus.mode  = MODE_HALT;
        exp_ticks = 0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        for (int i = 0; i < 17; i++) push_per(32'b1100, 4, 1'b0);
        bus.mode = MODE_RUN;
        cyc(68);
        bus.mode = MODE_HALT;
        cyc(8);
        chk("t6_tick_cnt_wrap", {28'd0, bus.tick_cnt}, 32'd1);
        chk("t6_busy_lost", {31'd0, bus.div_busy}, 32'd0);

        cyc(5);
        chk("periods_drained", exp_q.size(), 32'd0);
        chk("acks_drained", ack_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
